// File: rtl/vmem_arb_pkg.sv
// rtl/vmem_arb_pkg.sv - shared types and constants for the video memory write arbiter
package vmem_arb_pkg;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_RUN   = 2'd1,
        S_CLEAR = 2'd2
    } vmem_arb_state_t;

    localparam int VMEM_DEPTH = 4096;
    localparam int TEXT_COLS  = 64;
    localparam int TEXT_ROWS  = 48;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant selection with an owned rotating pointer
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req,
    input  logic                     enable,
    input  logic                     advance,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0]    ptr;
    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] pick_from;

    // Requests at or above ptr take precedence; otherwise wrap to the lowest request.
    always_comb begin
        masked = '0;
        for (int i = 0; i < N_REQ; i++) begin
            masked[i] = req[i] && (IW'(i) >= ptr);
        end
        pick_from = (|masked) ? masked : req;
        grant     = '0;
        idx       = '0;
        if (enable) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (pick_from[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    idx      = IW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/vmem_write_arbiter.sv
// rtl/vmem_write_arbiter.sv - shares the video memory write port between writers and a clear sequencer
module vmem_write_arbiter
    import vmem_arb_pkg::*;
#(
    parameter int                N_REQ      = 4,
    parameter int                ADDR_W     = 12,
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] CLEAR_CHAR = DATA_W'(8'h20)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          video_reset_done,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [N_REQ-1:0][DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]              req_ready,
    input  logic                          clear_req,
    output logic                          clear_busy,
    output logic [ADDR_W-1:0]             w_addr,
    output logic [DATA_W-1:0]             w_data,
    output logic                          w_valid,
    output logic [$clog2(N_REQ)-1:0]      grant_id
);

    localparam int                IW        = $clog2(N_REQ);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VMEM_DEPTH - 1);

    vmem_arb_state_t  state;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    idx;
    logic             arb_en;

    // Gating on video_reset_done keeps a write from landing after the memory drops out.
    assign arb_en    = (state == S_RUN) && !clear_req && video_reset_done;
    assign req_ready = grant;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_valid),
        .enable  (arb_en),
        .advance (|grant),
        .grant   (grant),
        .idx     (idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_WAIT;
            w_valid    <= 1'b0;
            w_addr     <= '0;
            w_data     <= '0;
            grant_id   <= '0;
            clear_busy <= 1'b0;
        end else if (!video_reset_done) begin
            state      <= S_WAIT;
            w_valid    <= 1'b0;
            clear_busy <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    state   <= S_RUN;
                    w_valid <= 1'b0;
                end
                S_RUN: begin
                    if (clear_req) begin
                        state      <= S_CLEAR;
                        clear_busy <= 1'b1;
                        w_valid    <= 1'b1;
                        w_addr     <= '0;
                        w_data     <= CLEAR_CHAR;
                    end else begin
                        w_valid <= |grant;
                        if (|grant) begin
                            w_addr   <= req_addr[idx];
                            w_data   <= req_data[idx];
                            grant_id <= idx;
                        end
                    end
                end
                S_CLEAR: begin
                    // w_addr doubles as the fill counter.
                    if (w_addr == LAST_ADDR) begin
                        state      <= S_RUN;
                        clear_busy <= 1'b0;
                        w_valid    <= 1'b0;
                    end else begin
                        w_addr  <= w_addr + 1'b1;
                        w_data  <= CLEAR_CHAR;
                        w_valid <= 1'b1;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_vmem_write_arbiter.sv
// tb/tb_vmem_write_arbiter.sv - scoreboard bench for vmem_write_arbiter
module tb_vmem_write_arbiter;

    localparam int N = 4;
    localparam int M_WAIT = 0, M_RUN = 1, M_CLEAR = 2;

    typedef struct {
        logic [11:0] a;
        logic [7:0]  d;
        int          id;
        bit          clr;
    } wr_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             done;
    logic [N-1:0]     rv;
    logic [N-1:0][11:0] ra;
    logic [N-1:0][7:0]  rd;
    logic             clr;
    logic [N-1:0]     req_ready;
    logic             clear_busy;
    logic [11:0]      w_addr;
    logic [7:0]       w_data;
    logic             w_valid;
    logic [1:0]       grant_id;

    int  n_cmp = 0;
    int  n_bad = 0;
    wr_t q[$];
    int  mode = M_WAIT;
    int  mptr = 0;
    int  cnt  = 0;
    bit  exp_busy = 1'b0;
    logic [N-1:0] acc_mask = '0;
    logic [N-1:0] obs_ready;
    logic         obs_busy, obs_wvalid;
    logic [11:0]  obs_waddr;

    vmem_write_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .video_reset_done (done),
        .req_valid        (rv),
        .req_addr         (ra),
        .req_data         (rd),
        .req_ready        (req_ready),
        .clear_req        (clr),
        .clear_busy       (clear_busy),
        .w_addr           (w_addr),
        .w_data           (w_data),
        .w_valid          (w_valid),
        .grant_id         (grant_id)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference: mode/pointer/fill-count bookkeeping; each cycle predicts readiness and the next write.
    task automatic step();
        logic [N-1:0] er;
        int p;
        #1;
        obs_ready  = req_ready;
        obs_busy   = clear_busy;
        obs_wvalid = w_valid;
        obs_waddr  = w_addr;
        er = '0;
        if (mode == M_RUN && done && !clr) begin
            for (int k = 0; k < N; k++) begin
                p = (mptr + k) % N;
                if (rv[p]) begin
                    er[p] = 1'b1;
                    q.push_back(wr_t'{ra[p], rd[p], p, 1'b0});
                    mptr = (p + 1) % N;
                    break;
                end
            end
        end
        chk("req_ready", 32'(req_ready), 32'(er));
        acc_mask = er;
        if (!done) begin
            mode = M_WAIT;
        end else if (mode == M_WAIT) begin
            mode = M_RUN;
        end else if (mode == M_RUN) begin
            if (clr) begin
                q.push_back(wr_t'{12'd0, 8'h20, 0, 1'b1});
                mode = M_CLEAR;
                cnt  = 1;
            end
        end else begin
            if (cnt < 4096) begin
                q.push_back(wr_t'{12'(cnt), 8'h20, 0, 1'b1});
                cnt++;
            end else begin
                mode = M_RUN;
            end
        end
        exp_busy = (mode == M_CLEAR);
        @(negedge clk);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_w_valid"},    32'(w_valid),    0);
        chk({tag, "_w_addr"},     32'(w_addr),     0);
        chk({tag, "_w_data"},     32'(w_data),     0);
        chk({tag, "_grant_id"},   32'(grant_id),   0);
        chk({tag, "_clear_busy"}, 32'(clear_busy), 0);
        chk({tag, "_req_ready"},  32'(req_ready),  0);
    endtask

    initial begin : monitor
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n) begin
                chk("clear_busy", 32'(clear_busy), 32'(exp_busy));
                chk("w_valid", 32'(w_valid), 32'(q.size() > 0));
                if (q.size() > 0) begin
                    e = q.pop_front();
                    if (w_valid) begin
                        chk("w_addr", 32'(w_addr), 32'(e.a));
                        chk("w_data", 32'(w_data), 32'(e.d));
                        if (!e.clr) chk("grant_id", 32'(grant_id), 32'(e.id));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [N-1:0] exp_seq2 [8];
        logic [N-1:0] exp_seq3 [4];
        int  busy_n;
        bit  got;
        logic [N-1:0] first;
        reset_n = 1'b0; done = 1'b0; rv = '0; ra = '0; rd = '0; clr = 1'b0;
        #12;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Memory not ready: requester 0 must be held off.
        rv[0] = 1'b1; ra[0] = 12'h123; rd[0] = 8'h41;
        repeat (20) step();
        done = 1'b1;
        step();
        step();
        chk("first_grant", 32'(obs_ready), 32'h1);
        rv = 4'b1000;
        step();

        for (int i = 0; i < N; i++) begin
            ra[i] = 12'h40 + 12'(i);
            rd[i] = 8'h30 + 8'(i);
        end
        exp_seq2 = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
        rv = '1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_all", 32'(obs_ready), 32'(exp_seq2[k]));
        end

        rv = 4'b0010;
        step();
        exp_seq3 = '{4'h8, 4'h2, 4'h8, 4'h2};
        rv = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_1_3", 32'(obs_ready), 32'(exp_seq3[k]));
        end

        // Clear beats a same-cycle request; a second clear mid-fill is ignored.
        rv = '1;
        clr = 1'b1;
        step();
        chk("clear_prio", 32'(obs_ready), 0);
        busy_n = 0; got = 1'b0; first = '0;
        for (int k = 1; k < 4200 && !got; k++) begin
            clr = (k == 50);
            step();
            if (obs_busy) busy_n++;
            if (obs_ready != 0) begin
                got = 1'b1;
                first = obs_ready;
            end
        end
        clr = 1'b0;
        chk("clear_resumed", 32'(got), 1);
        chk("clear_busy_cycles", busy_n, 4096);
        chk("resume_ptr", 32'(first), 32'h4);

        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!rv[i] || acc_mask[i]) begin
                    rv[i] = 1'($urandom_range(1));
                    ra[i] = 12'($urandom);
                    rd[i] = 8'($urandom);
                end
            end
            clr  = ($urandom_range(399) == 0);
            done = ($urandom_range(99) >= 2);
            step();
        end

        // Abandon a clear at address 100 by dropping video_reset_done.
        clr = 1'b0; done = 1'b1; rv = '0;
        for (int k = 0; k < 5000 && mode != M_RUN; k++) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (100) step();
        done = 1'b0;
        step();
        chk("drop_last_wvalid", 32'(obs_wvalid), 1);
        chk("drop_last_waddr", 32'(obs_waddr), 100);
        step();
        chk("drop_wvalid", 32'(obs_wvalid), 0);
        chk("drop_busy", 32'(obs_busy), 0);
        step();
        done = 1'b1;
        repeat (5) step();

        // Asynchronous reset while a write is on the port.
        for (int i = 0; i < N; i++) begin
            ra[i] = 12'h200 + 12'(i);
            rd[i] = 8'h50 + 8'(i);
        end
        rv = '1;
        step();
        chk("pre_reset_wvalid", 32'(w_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        q.delete();
        mode = M_WAIT; mptr = 0; exp_busy = 1'b0; acc_mask = '0;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        step();
        chk("post_reset_grant", 32'(obs_ready), 32'h1);
        rv = '0;
        repeat (3) step();
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
